// File: rtl/tmds_pkg.sv
// Shared TMDS symbol definitions: control tokens, TERC4 code table, guard
// bands and the enums used by TMDS receive/transmit logic.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_DI = 10'b0100110011;
  localparam logic [9:0] VIDEO_GB = 10'b1011001100;

  typedef enum logic [1:0] {
    SYM_VIDEO    = 2'd0,
    SYM_CTRL     = 2'd1,
    SYM_TERC4    = 2'd2,
    SYM_GUARD_DI = 2'd3
  } sym_type_t;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SLIP   = 2'd1,
    WAIT   = 2'd2,
    LOCKED = 2'd3
  } align_state_t;

  function automatic logic [9:0] terc4_code(input logic [3:0] v);
    case (v)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational classify/decode of one aligned 10-bit TMDS symbol.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] i_sym,
  output sym_type_t  o_sym_type,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic [3:0] o_terc4
);

  logic [7:0] w_qp;
  logic       w_terc_hit;
  logic [3:0] w_terc_val;

  assign w_qp   = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
  assign o_data = {(w_qp[7:1] ^ w_qp[6:0]) ^ {7{~i_sym[8]}}, w_qp[0]};

  always_comb begin
    w_terc_hit = 1'b0;
    w_terc_val = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (i_sym == terc4_code(4'(i))) begin
        w_terc_hit = 1'b1;
        w_terc_val = 4'(i);
      end
    end
  end

  // The video guard band shares its code with TERC4 1000; context resolves it downstream.
  always_comb begin
    o_sym_type = SYM_VIDEO;
    o_ctrl     = 2'b00;
    o_terc4    = 4'h0;
    case (i_sym)
      CTRL_TOK_00: begin o_sym_type = SYM_CTRL; o_ctrl = 2'b00; end
      CTRL_TOK_01: begin o_sym_type = SYM_CTRL; o_ctrl = 2'b01; end
      CTRL_TOK_10: begin o_sym_type = SYM_CTRL; o_ctrl = 2'b10; end
      CTRL_TOK_11: begin o_sym_type = SYM_CTRL; o_ctrl = 2'b11; end
      default: begin
        if (i_sym == VIDEO_GB) begin
          o_sym_type = SYM_TERC4;
          o_terc4    = 4'h8;
        end else if (w_terc_hit) begin
          o_sym_type = SYM_TERC4;
          o_terc4    = w_terc_val;
        end else if (i_sym == GUARD_DI) begin
          o_sym_type = SYM_GUARD_DI;
        end
      end
    endcase
  end

endmodule

// File: rtl/tmds_rx_decoder.sv
// Per-channel TMDS receiver: control-token based symbol alignment with
// bitslip requests, plus a two-stage symbol decode pipeline.
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN    = 8,
  parameter int HUNT_WINDOW = 2048,
  parameter int SLIP_WAIT   = 4,
  parameter int LOSS_WINDOW = 4096
) (
  input  logic       clk_pixel,
  input  logic       sys_resetn,
  input  logic [9:0] tmds_word,
  output logic       bitslip,
  output logic       locked,
  output logic [3:0] slip_count,
  output logic [1:0] sym_type,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic [3:0] terc4
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int HUNT_W = $clog2(HUNT_WINDOW + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int LOSS_W = $clog2(LOSS_WINDOW + 1);

  logic [9:0]   r_q;
  sym_type_t    r_sym_type;
  logic [7:0]   r_data;
  logic [1:0]   r_ctrl;
  logic [3:0]   r_terc4;

  align_state_t r_state;
  logic [RUN_W-1:0]  r_run_cnt;
  logic [HUNT_W-1:0] r_hunt_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [LOSS_W-1:0] r_loss_cnt;
  logic         r_bitslip;
  logic         r_locked;
  logic [3:0]   r_slip_count;

  sym_type_t    w_dec_type;
  logic [7:0]   w_dec_data;
  logic [1:0]   w_dec_ctrl;
  logic [3:0]   w_dec_terc4;
  logic         w_is_ctrl;
  logic         w_run_done;

  tmds_symbol_decode u_decode (
    .i_sym      (r_q),
    .o_sym_type (w_dec_type),
    .o_data     (w_dec_data),
    .o_ctrl     (w_dec_ctrl),
    .o_terc4    (w_dec_terc4)
  );

  assign w_is_ctrl  = (w_dec_type == SYM_CTRL);
  assign w_run_done = w_is_ctrl && (r_run_cnt == RUN_W'(CTRL_RUN - 1));

  always_ff @(posedge clk_pixel) begin
    if (!sys_resetn) begin
      r_q        <= '0;
      r_sym_type <= SYM_VIDEO;
      r_data     <= '0;
      r_ctrl     <= '0;
      r_terc4    <= '0;
    end else begin
      r_q        <= tmds_word;
      r_sym_type <= w_dec_type;
      r_data     <= w_dec_data;
      r_ctrl     <= w_dec_ctrl;
      r_terc4    <= w_dec_terc4;
    end
  end

  // Counters are bounded by their terminal compares, so they never wrap.
  always_ff @(posedge clk_pixel) begin
    if (!sys_resetn) begin
      r_state      <= HUNT;
      r_run_cnt    <= '0;
      r_hunt_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_loss_cnt   <= '0;
      r_bitslip    <= 1'b0;
      r_locked     <= 1'b0;
      r_slip_count <= '0;
    end else begin
      r_bitslip <= 1'b0;
      case (r_state)
        HUNT: begin
          if (w_run_done) begin
            r_state    <= LOCKED;
            r_locked   <= 1'b1;
            r_run_cnt  <= '0;
            r_loss_cnt <= '0;
          end else if (r_hunt_cnt == HUNT_W'(HUNT_WINDOW - 1)) begin
            r_state      <= SLIP;
            r_bitslip    <= 1'b1;
            r_slip_count <= (r_slip_count == 4'd9) ? 4'd0 : r_slip_count + 4'd1;
          end else begin
            r_hunt_cnt <= r_hunt_cnt + HUNT_W'(1);
            r_run_cnt  <= w_is_ctrl ? r_run_cnt + RUN_W'(1) : '0;
          end
        end
        SLIP: begin
          r_state    <= WAIT;
          r_wait_cnt <= '0;
        end
        WAIT: begin
          if (r_wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
            r_state    <= HUNT;
            r_run_cnt  <= '0;
            r_hunt_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        LOCKED: begin
          r_run_cnt <= (w_is_ctrl && !w_run_done) ? r_run_cnt + RUN_W'(1) : '0;
          if (w_run_done) begin
            r_loss_cnt <= '0;
          end else if (r_loss_cnt == LOSS_W'(LOSS_WINDOW - 1)) begin
            r_state      <= HUNT;
            r_locked     <= 1'b0;
            r_slip_count <= '0;
            r_hunt_cnt   <= '0;
            r_run_cnt    <= '0;
          end else begin
            r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign bitslip    = r_bitslip;
  assign locked     = r_locked;
  assign slip_count = r_slip_count;
  assign sym_type   = r_sym_type;
  assign data       = r_data;
  assign ctrl       = r_ctrl;
  assign terc4      = r_terc4;

endmodule
